cache_controller: RTL and testbench

Write-through, no-write-allocate controller FSM sitting directly upstream of the cache data/tag array in the RISC-V memory path. Decodes CPU load/store requests against the array's `hit` flag, drives the array's `refill`/`update` command pair, sequences main-memory block reads and word writes with a fixed-latency counter, and stalls the core until each access completes.

---
 rtl/cache_controller.sv | 102 ++++++++++
 tb/tb_cache_controller.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate cache controller: decodes CPU loads/stores
// against the array hit flag and sequences fixed-latency main-memory accesses.
module cache_controller #(
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = $clog2(MEM_LATENCY + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_read,
  input  logic mem_write,
  input  logic hit,
  output logic refill,
  output logic update,
  output logic stall,
  output logic mem_rd_en,
  output logic mem_wr_en
);

  typedef enum logic [1:0] {IDLE, RD_MISS, REFILL, WR_MEM} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LATENCY - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wr_hit;
  logic             last;

  assign last = (cnt == LAST);

  // cnt holds at LAST on the final memory cycle instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      wr_hit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_write) begin
            wr_hit <= hit;
            cnt    <= '0;
            state  <= WR_MEM;
          end else if (mem_read && !hit) begin
            cnt    <= '0;
            state  <= RD_MISS;
          end
        end
        RD_MISS: begin
          if (last) state <= REFILL;
          else      cnt   <= cnt + CNT_W'(1);
        end
        REFILL: state <= IDLE;
        WR_MEM: begin
          if (last) state <= IDLE;
          else      cnt   <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs follow the live request in IDLE, so they are decoded combinationally;
  // reset masks everything so an aborted access never leaks a command.
  always_comb begin
    refill    = 1'b0;
    update    = 1'b0;
    stall     = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (mem_write) begin
            stall = 1'b1;
          end else if (mem_read) begin
            if (hit) begin
              update = 1'b1;
              refill = 1'b1;
            end else begin
              stall = 1'b1;
            end
          end
        end
        RD_MISS: begin
          mem_rd_en = 1'b1;
          stall     = 1'b1;
        end
        REFILL: begin
          refill = 1'b1;
          stall  = 1'b1;
        end
        WR_MEM: begin
          mem_wr_en = 1'b1;
          stall     = !last;
          update    = last && wr_hit;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: scripted cycle table plus random traffic checked
// against a transaction-level model, on MEM_LATENCY=4 and MEM_LATENCY=1 instances.
module tb_cache_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, mem_read, mem_write, hit;
  logic refill4, update4, stall4, rd4, wr4;
  logic refill1, update1, stall1, rd1, wr1;

  cache_controller #(.MEM_LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .hit(hit),
    .refill(refill4), .update(update4), .stall(stall4), .mem_rd_en(rd4), .mem_wr_en(wr4)
  );

  cache_controller #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .hit(hit),
    .refill(refill1), .update(update1), .stall(stall1), .mem_rd_en(rd1), .mem_wr_en(wr1)
  );

  // Output vectors are {update, refill, stall, mem_rd_en, mem_wr_en}
  typedef struct {
    logic       rst;
    logic       rd;
    logic       wr;
    logic       h;
    logic [4:0] exp;
  } vec_t;

  vec_t       tab[$];
  logic [4:0] q0[$];
  logic [4:0] q1[$];
  int         checks   = 0;
  int         failures = 0;

  task automatic check(input string name, input int idx, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%b want=%b ({upd,ref,stall,rd,wr})", name, idx, act, exp);
    end
  endtask

  task automatic push(input int which, input logic [4:0] v);
    if (which == 0) q0.push_back(v);
    else            q1.push_back(v);
  endtask

  // An accepted request schedules its whole future output sequence; while that
  // schedule is non-empty the controller is busy and ignores the inputs.
  task automatic model(input int which, input int lat, output logic [4:0] e);
    int n;
    n = (which == 0) ? q0.size() : q1.size();
    if (reset) begin
      e = 5'b00000;
      if (which == 0) q0.delete();
      else            q1.delete();
    end else if (n > 0) begin
      if (which == 0) e = q0.pop_front();
      else            e = q1.pop_front();
    end else if (mem_write) begin
      e = 5'b00100;
      for (int i = 0; i < lat - 1; i++) push(which, 5'b00101);
      push(which, hit ? 5'b10001 : 5'b00001);
    end else if (mem_read && hit) begin
      e = 5'b11000;
    end else if (mem_read) begin
      e = 5'b00100;
      for (int i = 0; i < lat; i++) push(which, 5'b00110);
      push(which, 5'b01100);
    end else begin
      e = 5'b00000;
    end
  endtask

  task automatic cycle(input logic r, input logic rd, input logic wr, input logic h,
                       input int row, input logic [4:0] texp, input bit use_tab);
    logic [4:0] e0, e1;
    reset = r; mem_read = rd; mem_write = wr; hit = h;
    #1;
    model(0, 4, e0);
    model(1, 1, e1);
    @(negedge clk);
    check("lat4_model", row, {update4, refill4, stall4, rd4, wr4}, e0);
    check("lat1_model", row, {update1, refill1, stall1, rd1, wr1}, e1);
    if (use_tab) check("table", row, {update4, refill4, stall4, rd4, wr4}, texp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0;

    // Cycle-by-cycle script for MEM_LATENCY=4
    tab.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 5'b00000}); // reset masks read hit
    tab.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 5'b00000}); // reset masks store
    tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5'b00000}); // idle
    tab.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 5'b11000}); // read hit
    tab.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 5'b11000}); // read hit again
    tab.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 5'b00100}); // read miss decode
    for (int i = 0; i < 4; i++)
      tab.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 5'b00110}); // RD_MISS
    tab.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 5'b01100}); // REFILL
    tab.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 5'b11000}); // read served
    tab.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 5'b00100}); // write hit decode
    for (int i = 0; i < 3; i++)
      tab.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 5'b00101});
    tab.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 5'b10001}); // write hit retires, latched hit
    tab.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 5'b00100}); // write miss back-to-back
    for (int i = 0; i < 3; i++)
      tab.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 5'b00101});
    tab.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 5'b00001}); // no allocate on write miss
    tab.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 5'b00100}); // read+write: store wins
    for (int i = 0; i < 3; i++)
      tab.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 5'b00101});
    tab.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 5'b10001});
    tab.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 5'b00100}); // read miss
    tab.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 5'b00110}); // RD_MISS 1
    tab.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 5'b00000}); // reset in RD_MISS 2
    tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5'b00000}); // aborted: no enable
    tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5'b00000}); // and no refill
    tab.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 5'b00100}); // store, then request dropped
    for (int i = 0; i < 3; i++)
      tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5'b00101});
    tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5'b10001}); // still completes
    tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 5'b00000});

    @(posedge clk);
    #1;
    for (int i = 0; i < tab.size(); i++)
      cycle(tab[i].rst, tab[i].rd, tab[i].wr, tab[i].h, i, tab[i].exp, 1'b1);

    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            1000 + i, 5'b00000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
